// File: rtl/alu16.sv
// rtl/alu16.sv - 16-bit 8-operation ALU with registered, valid-qualified result; status flags when ALU_FLAGS_EN is defined
module alu16 #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] result,
`ifdef ALU_FLAGS_EN
    output logic             out_valid,
    output logic [3:0]       flags
`else
    output logic             out_valid
`endif
);

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_SHIFTR = 3'd2,
        OP_SHIFTL = 3'd3,
        OP_AND    = 3'd4,
        OP_OR     = 3'd5,
        OP_NOT    = 3'd6,
        OP_XOR    = 3'd7
    } op_e;

    op_e                op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   res_next;

    assign op    = op_e'(mode);
    assign shamt = in2[SHAMT_W-1:0];

`ifdef ALU_FLAGS_EN
    logic c_next;
    logic v_next;

    // Operation select with carry/overflow; shifts run one bit wider so the
    // last bit shifted out lands in the extra position (and is 0 for amt=0).
    always_comb begin
        res_next = '0;
        c_next   = 1'b0;
        v_next   = 1'b0;
        case (op)
            OP_ADD: begin
                {c_next, res_next} = {1'b0, in1} + {1'b0, in2};
                v_next = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                         (res_next[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                {c_next, res_next} = {1'b0, in1} - {1'b0, in2};
                v_next = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                         (res_next[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SHIFTR: {res_next, c_next} = {in1, 1'b0} >> shamt;
            OP_SHIFTL: {c_next, res_next} = {1'b0, in1} << shamt;
            OP_AND:    res_next = in1 & in2;
            OP_OR:     res_next = in1 | in2;
            OP_NOT:    res_next = ~in1;
            OP_XOR:    res_next = in1 ^ in2;
            default:   res_next = '0;
        endcase
    end

    // Result, flags and valid register; result/flags only move on a valid op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            flags     <= 4'b0000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= res_next;
                flags  <= {(res_next == '0), res_next[WIDTH-1], c_next, v_next};
            end
        end
    end
`else
    // Operation select; results only, no status computation.
    always_comb begin
        res_next = '0;
        case (op)
            OP_ADD:    res_next = in1 + in2;
            OP_SUB:    res_next = in1 - in2;
            OP_SHIFTR: res_next = in1 >> shamt;
            OP_SHIFTL: res_next = in1 << shamt;
            OP_AND:    res_next = in1 & in2;
            OP_OR:     res_next = in1 | in2;
            OP_NOT:    res_next = ~in1;
            OP_XOR:    res_next = in1 ^ in2;
            default:   res_next = '0;
        endcase
    end

    // Result and valid register; result only moves on a valid op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= res_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu16.sv
// tb/tb_alu16.sv - randomized and directed bench for alu16 against an arithmetic reference model
module tb_alu16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [2:0]  mode;
    logic [15:0] result;
    logic        out_valid;
`ifdef ALU_FLAGS_EN
    logic [3:0]  flags;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_res   = 16'h0000;
    logic        exp_valid = 1'b0;
    logic [3:0]  exp_flags = 4'b0000;

    alu16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .mode      (mode),
        .result    (result),
`ifdef ALU_FLAGS_EN
        .out_valid (out_valid),
        .flags     (flags)
`else
        .out_valid (out_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic int to_signed(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    // Reference: returns {C, V, result[15:0]} from plain integer arithmetic.
    function automatic logic [17:0] ref_op(input int unsigned a, input int unsigned b, input int m);
        int unsigned r = 0;
        int unsigned amt = b % 16;
        int          s = 0;
        logic        c = 1'b0;
        logic        v = 1'b0;
        case (m)
            0: begin
                r = (a + b) % 65536;
                c = (a + b) > 65535;
                s = to_signed(a) + to_signed(b);
                v = (s > 32767) || (s < -32768);
            end
            1: begin
                r = (a + 65536 - b) % 65536;
                c = a < b;
                s = to_signed(a) - to_signed(b);
                v = (s > 32767) || (s < -32768);
            end
            2: begin
                r = a / (1 << amt);
                c = (amt != 0) ? ((a / (1 << (amt - 1))) % 2 == 1) : 1'b0;
            end
            3: begin
                r = (a * (1 << amt)) % 65536;
                c = (amt != 0) ? ((a / (1 << (16 - amt))) % 2 == 1) : 1'b0;
            end
            4: r = a & b;
            5: r = a | b;
            6: r = 65535 - a;
            default: r = a ^ b;
        endcase
        return {c, v, r[15:0]};
    endfunction

    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [2:0] m);
        logic [17:0] r;
        @(negedge clk);
        in_valid = v;
        in1      = a;
        in2      = b;
        mode     = m;
        @(posedge clk);
        r = ref_op(a, b, m);
        if (v) begin
            exp_res   = r[15:0];
            exp_flags = {(r[15:0] == 16'h0000), r[15], r[17], r[16]};
        end
        exp_valid = v;
        #1;
        check($sformatf("out_valid m%0d", m), 32'(out_valid), 32'(exp_valid));
        check($sformatf("result m%0d a=%h b=%h", m, a, b), 32'(result), 32'(exp_res));
`ifdef ALU_FLAGS_EN
        check($sformatf("flags m%0d a=%h b=%h", m, a, b), 32'(flags), 32'(exp_flags));
`endif
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  m;
        logic [15:0] want;
        logic [3:0]  want_flags;
    } vec_t;

    vec_t dir[$];

    task automatic check_reset_state(input string tag);
        check({tag, " result"}, 32'(result), 32'h0);
        check({tag, " out_valid"}, 32'(out_valid), 32'h0);
`ifdef ALU_FLAGS_EN
        check({tag, " flags"}, 32'(flags), 32'h0);
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in1      = 16'h1234;
        in2      = 16'h4321;
        mode     = 3'd0;
        #2;
        check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: {in1, in2, mode, result, {Z,N,C,V}}
        dir.push_back('{16'd100,  16'd35,    3'd1, 16'd65,    4'b0000});
        dir.push_back('{16'd0,    16'd32766, 3'd1, 16'h8002,  4'b0110});
        dir.push_back('{16'hFFFF, 16'h0001,  3'd0, 16'h0000,  4'b1010});
        dir.push_back('{16'h7FFF, 16'h0001,  3'd0, 16'h8000,  4'b0101});
        dir.push_back('{16'h8001, 16'h0001,  3'd2, 16'h4000,  4'b0010});
        dir.push_back('{16'h8001, 16'h0001,  3'd3, 16'h0002,  4'b0010});
        dir.push_back('{16'h8001, 16'h0010,  3'd2, 16'h8001,  4'b0100});
        dir.push_back('{16'h8001, 16'h0010,  3'd3, 16'h8001,  4'b0100});
        dir.push_back('{16'hF0F0, 16'hFF00,  3'd4, 16'hF000,  4'b0100});
        dir.push_back('{16'hF0F0, 16'hFF00,  3'd5, 16'hFFF0,  4'b0100});
        dir.push_back('{16'hF0F0, 16'hFF00,  3'd7, 16'h0FF0,  4'b0000});
        dir.push_back('{16'hF0F0, 16'hFF00,  3'd6, 16'h0F0F,  4'b0000});

        foreach (dir[i]) begin
            step(1'b1, dir[i].a, dir[i].b, dir[i].m);
            check($sformatf("directed %0d result", i), 32'(result), 32'(dir[i].want));
`ifdef ALU_FLAGS_EN
            check($sformatf("directed %0d flags", i), 32'(flags), 32'(dir[i].want_flags));
`endif
        end

        // Idle cycle: valid drops, result held from the last directed op.
        step(1'b0, 16'hAAAA, 16'h5555, 3'd0);
        check("idle hold", 32'(result), 32'h0F0F);

        // Async reset mid-stream with in_valid high, no clock edge needed.
        step(1'b1, 16'h1111, 16'h2222, 3'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in1      = 16'h0F00;
        in2      = 16'h00F0;
        mode     = 3'd5;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async reset");
        @(posedge clk);
        #1;
        check_reset_state("reset held");
        exp_res   = 16'h0000;
        exp_valid = 1'b0;
        exp_flags = 4'b0000;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step(1'b0, 16'h0F00, 16'h00F0, 3'd5);

        // Randomized stream, mostly back-to-back valid ops.
        for (int n = 0; n < 400; n++) begin
            logic        v;
            logic [15:0] a;
            logic [15:0] b;
            v = ($urandom_range(0, 4) != 0);
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0: a = 16'hFFFF;
                1: a = 16'h8000;
                2: b = 16'h0000;
                3: b = 16'h7FFF;
                default: ;
            endcase
            step(v, a, b, 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
